// File: rtl/line_fetch_scheduler.sv
// rtl/line_fetch_scheduler.sv - ping-pong linebuffer refill sequencer for the video output path.
// Optional data-beat watchdog enabled by defining FETCH_TIMEOUT_EN.
module line_fetch_scheduler #(
    parameter int                         ADDRESS_WIDTH  = 32,
    parameter int                         LB_ADDR_WIDTH  = 10,
    parameter int                         DISPLAY_WIDTH  = 640,
    parameter int                         DISPLAY_HEIGHT = 480,
    parameter logic [ADDRESS_WIDTH-1:0]   FB_BASE        = 32'h1000_0000,
    parameter int                         BURST_WORDS    = 16
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int                         TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     req_line,
    input  logic                     req_frame,
    output logic                     rd_req_valid,
    input  logic                     rd_req_ready,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [7:0]               rd_len,
    input  logic                     rd_data_valid,
    input  logic [31:0]              rd_data,
    output logic                     lb_we,
    output logic [LB_ADDR_WIDTH-1:0] lb_waddr,
    output logic [31:0]              lb_wdata,
    output logic                     disp_bank,
    output logic                     busy,
    output logic                     fetch_done,
    output logic [15:0]              underrun_cnt
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
    typedef logic [LB_ADDR_WIDTH-1:0] ptr_t;

    localparam int          WPL       = DISPLAY_WIDTH / 4;
    localparam ptr_t        WPL_P     = ptr_t'(WPL);
    localparam ptr_t        BURST_P   = ptr_t'(BURST_WORDS);
    localparam logic [15:0] LAST_LINE = 16'(DISPLAY_HEIGHT - 1);

    state_t      state;
    logic        req_line_q, req_line_qq, req_frame_q, req_frame_qq;
    logic        fill_bank, fetch_bank;
    logic [15:0] line_idx, fetch_line;
    ptr_t        word_ptr;
    logic [7:0]  beats_left;
`ifdef FETCH_TIMEOUT_EN
    logic [31:0] to_cnt;
`endif

    function automatic logic [ADDRESS_WIDTH-1:0] burst_addr(input logic [15:0] line, input ptr_t ptr);
        return FB_BASE + ADDRESS_WIDTH'(line) * ADDRESS_WIDTH'(DISPLAY_WIDTH)
                       + (ADDRESS_WIDTH'(ptr) << 2);
    endfunction

    function automatic logic [7:0] burst_len(input ptr_t ptr);
        ptr_t rem;
        rem = WPL_P - ptr;
        return (rem > BURST_P) ? 8'(BURST_P) : 8'(rem);
    endfunction

    logic        line_edge, frame_edge;
    logic [15:0] cur_line, next_line;
    ptr_t        ptr_next;

    // A frame edge resets the line counter before a same-cycle line edge samples it.
    assign line_edge  = req_line_q & ~req_line_qq;
    assign frame_edge = req_frame_q & ~req_frame_qq;
    assign cur_line   = frame_edge ? 16'd0 : line_idx;
    assign next_line  = (cur_line == LAST_LINE) ? 16'd0 : cur_line + 16'd1;
    assign ptr_next   = word_ptr + ptr_t'(1);

    assign rd_req_valid = (state == ISSUE);
    assign busy         = (state != IDLE);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_line_q   <= 1'b0;
            req_line_qq  <= 1'b0;
            req_frame_q  <= 1'b0;
            req_frame_qq <= 1'b0;
            fill_bank    <= 1'b1;
            fetch_bank   <= 1'b0;
            line_idx     <= '0;
            fetch_line   <= '0;
            word_ptr     <= '0;
            beats_left   <= '0;
            rd_addr      <= '0;
            rd_len       <= '0;
            lb_we        <= 1'b0;
            lb_waddr     <= '0;
            lb_wdata     <= '0;
            disp_bank    <= 1'b0;
            fetch_done   <= 1'b0;
            underrun_cnt <= '0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            req_line_q   <= req_line;
            req_line_qq  <= req_line_q;
            req_frame_q  <= req_frame;
            req_frame_qq <= req_frame_q;
            lb_we        <= 1'b0;
            fetch_done   <= 1'b0;

            if (frame_edge)
                line_idx <= 16'd0;
            if (line_edge) begin
                line_idx <= next_line;
                if (state != IDLE && underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (line_edge) begin
                        disp_bank  <= fill_bank;
                        fill_bank  <= ~fill_bank;
                        fetch_bank <= fill_bank;
                        fetch_line <= cur_line;
                        word_ptr   <= '0;
                        rd_addr    <= burst_addr(cur_line, '0);
                        rd_len     <= burst_len('0);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_req_ready) begin
                        beats_left <= rd_len;
                        state      <= DATA;
`ifdef FETCH_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (rd_data_valid) begin
                        lb_we      <= 1'b1;
                        lb_waddr   <= {fetch_bank, word_ptr[LB_ADDR_WIDTH-2:0]};
                        lb_wdata   <= rd_data;
                        word_ptr   <= ptr_next;
                        beats_left <= beats_left - 8'd1;
`ifdef FETCH_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        if (beats_left == 8'd1) begin
                            if (ptr_next == WPL_P) begin
                                state      <= IDLE;
                                fetch_done <= 1'b1;
                            end else begin
                                rd_addr <= burst_addr(fetch_line, ptr_next);
                                rd_len  <= burst_len(ptr_next);
                                state   <= ISSUE;
                            end
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Abandon the line; whatever was written stays in the bank.
                    else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// tb/tb_line_fetch_scheduler.sv - scoreboard bench for line_fetch_scheduler.
module tb_line_fetch_scheduler;

    localparam int          W  = 64;
    localparam int          H  = 4;
    localparam int          B  = 8;
    localparam logic [31:0] FB = 32'h1000;
    localparam int          WPL = W / 4;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        req_line = 1'b0;
    logic        req_frame = 1'b0;
    logic        rd_req_ready = 1'b1;
    logic        rd_data_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        rd_req_valid;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        lb_we;
    logic [9:0]  lb_waddr;
    logic [31:0] lb_wdata;
    logic        disp_bank;
    logic        busy;
    logic        fetch_done;
    logic [15:0] underrun_cnt;
`ifdef FETCH_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 pclk = ~pclk;

    line_fetch_scheduler #(
        .ADDRESS_WIDTH (32),
        .LB_ADDR_WIDTH (10),
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .FB_BASE       (FB),
        .BURST_WORDS   (B)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(32)
`endif
    ) dut (
        .pclk         (pclk),
        .reset        (reset),
        .req_line     (req_line),
        .req_frame    (req_frame),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data),
        .lb_we        (lb_we),
        .lb_waddr     (lb_waddr),
        .lb_wdata     (lb_wdata),
        .disp_bank    (disp_bank),
        .busy         (busy),
        .fetch_done   (fetch_done),
        .underrun_cnt (underrun_cnt)
`ifdef FETCH_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [39:0] cmd_q[$];
    logic [41:0] wr_q[$];
    int          m_line = 0;
    logic        m_fill = 1'b1;
    logic        m_disp = 1'b0;
    int          exp_seq = 0;
    int          drv_seq = 0;
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (fetch_done) done_cnt++;
        if (rd_req_valid && rd_req_ready) begin
            if (cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_q.size()), 64'd1);
            else check("cmd", {rd_addr, rd_len}, cmd_q.pop_front());
        end
        if (lb_we) begin
            if (wr_q.size() == 0) check("write_unexpected", 64'(wr_q.size()), 64'd1);
            else check("write", {lb_waddr, lb_wdata}, wr_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Reference model of one accepted line request.
    task automatic push_request(input bit frame);
        int   fetch;
        logic bank;
        if (frame) m_line = 0;
        fetch  = m_line;
        bank   = m_fill;
        m_disp = m_fill;
        m_fill = ~m_fill;
        m_line = (m_line == H - 1) ? 0 : m_line + 1;
        for (int b = 0; b < WPL / B; b++)
            cmd_q.push_back({FB + 32'(fetch * W) + 32'(b * B * 4), 8'(B)});
        for (int p = 0; p < WPL; p++) begin
            wr_q.push_back({bank, 9'(p), 32'(exp_seq)});
            exp_seq++;
        end
    endtask

    task automatic pulse(input bit line, input bit frame);
        req_line  = line;
        req_frame = frame;
        tick();
        tick();
        req_line  = 1'b0;
        req_frame = 1'b0;
    endtask

    task automatic wait_cmd();
        bit found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_req_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("cmd_wait", 64'(found), 64'd1);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'(drv_seq);
            drv_seq++;
            tick();
        end
        rd_data_valid = 1'b0;
    endtask

    task automatic serve_line();
        for (int b = 0; b < WPL / B; b++) begin
            wait_cmd();
            tick();
            beats(B);
        end
        tick();
        check("wr_drain", 64'(wr_q.size()), 64'd0);
        check("cmd_drain", 64'(cmd_q.size()), 64'd0);
        check("idle_after_line", 64'(busy), 64'd0);
    endtask

    initial begin
        int d;
        tick();
        tick();
        check("rst_valid", 64'(rd_req_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(lb_we), 64'd0);
        check("rst_disp", 64'(disp_bank), 64'd0);
        check("rst_done", 64'(fetch_done), 64'd0);
        check("rst_underrun", 64'(underrun_cnt), 64'd0);
        check("rst_addr_len", {rd_addr, rd_len}, 64'd0);
        reset = 1'b0;
        tick();

        // single line: commands 0x1000/0x1020, writes 0x200.. with data 0..15
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        check("disp_first", 64'(disp_bank), 64'(m_disp));
        serve_line();
        check("done_single", 64'(done_cnt), 64'd1);

        // lines 1..3 then wrap to line 0
        for (int k = 0; k < 4; k++) begin
            push_request(1'b0);
            pulse(1'b1, 1'b0);
            check("disp_toggle", 64'(disp_bank), 64'(m_disp));
            serve_line();
        end
        check("done_prog", 64'(done_cnt), 64'd5);

        // frame resync: line 1, then line+frame together fetch line 0
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        serve_line();
        push_request(1'b1);
        pulse(1'b1, 1'b1);
        serve_line();

        // underrun during DATA
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        wait_cmd();
        tick();
        beats(3);
        m_line = (m_line == H - 1) ? 0 : m_line + 1;
        pulse(1'b1, 1'b0);
        check("underrun_cnt", 64'(underrun_cnt), 64'd1);
        check("underrun_disp", 64'(disp_bank), 64'(m_disp));
        check("underrun_busy", 64'(busy), 64'd1);
        beats(B - 3);
        wait_cmd();
        tick();
        beats(B);
        tick();
        check("underrun_drain", 64'(wr_q.size()), 64'd0);
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        serve_line();

        // command backpressure
        rd_req_ready = 1'b0;
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        wait_cmd();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rd_req_valid), 64'd1);
            check("bp_cmd", {rd_addr, rd_len}, cmd_q[0]);
            tick();
        end
        rd_req_ready = 1'b1;
        tick();
        check("bp_accepted", 64'(rd_req_valid), 64'd0);
        beats(B);
        wait_cmd();
        tick();
        beats(B);
        tick();
        check("bp_drain", 64'(wr_q.size()), 64'd0);

`ifdef FETCH_TIMEOUT_EN
        // watchdog: 3 beats then silence
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        wait_cmd();
        tick();
        beats(3);
        d = done_cnt;
        repeat (28) tick();
        check("to_still_busy", 64'(busy), 64'd1);
        repeat (8) tick();
        check("to_idle", 64'(busy), 64'd0);
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_no_done", 64'(done_cnt), 64'(d));
        wr_q.delete();
        cmd_q.delete();
        exp_seq = drv_seq;
`endif

        // asynchronous reset mid-burst
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        wait_cmd();
        tick();
        rd_data_valid = 1'b1;
        rd_data       = 32'hDEAD_BEEF;
        tick();
        check("pre_reset_we", 64'(lb_we), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_we", 64'(lb_we), 64'd0);
        check("ar_wdata", 64'(lb_wdata), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_disp", 64'(disp_bank), 64'd0);
        check("ar_underrun", 64'(underrun_cnt), 64'd0);
        check("ar_addr_len", {rd_addr, rd_len}, 64'd0);
        rd_data_valid = 1'b0;
        wr_q.delete();
        cmd_q.delete();
        m_line  = 0;
        m_fill  = 1'b1;
        exp_seq = drv_seq;
        tick();
        reset = 1'b0;
        tick();
        push_request(1'b0);
        pulse(1'b1, 1'b0);
        check("post_reset_disp", 64'(disp_bank), 64'd1);
        serve_line();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
